regfile_wb_arb: RTL and testbench

REGFILE_WB_ARB -- requirements
Module: regfile_wb_arb

---
 rtl/regfile_pkg.sv | 26 ++
 rtl/wb_fifo.sv | 56 +++++
 rtl/regfile_wb_arb.sv | 97 +++++++++
 tb/tb_regfile_wb_arb.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared types and constants for the register-file writeback arbiter.
package regfile_pkg;

  localparam logic [4:0] XZR_IDX = 5'd31;
  localparam int         REG_AW  = 5;
  localparam int         REG_DW  = 64;

  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [REG_DW-1:0] data;
  } wb_req_t;

  typedef enum logic {
    GNT_ALU = 1'b0,
    GNT_MEM = 1'b1
  } gnt_e;

  // One-hot register mask that never flags the zero register.
  function automatic logic [31:0] reg_bit(input logic [REG_AW-1:0] idx);
    logic [31:0] m;
    m = 32'(1) << idx;
    m[XZR_IDX] = 1'b0;
    return m;
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// DEPTH-entry synchronous FIFO for writeback requests; also reports which
// destination registers are held by the live entries.
module wb_fifo
  import regfile_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  logic        pop,
  input  wb_req_t     din,
  output logic        full,
  output logic        empty,
  output wb_req_t     head,
  output logic [31:0] rd_mask
);

  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = AW + 1;

  wb_req_t          mem [DEPTH];
  logic [AW-1:0]    wptr, rptr, off;
  logic [CNT_W-1:0] cnt;

  assign full  = (cnt == CNT_W'(DEPTH));
  assign empty = (cnt == '0);
  assign head  = mem[rptr];

  // DEPTH is a power of two, so pointers wrap by plain overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (push) begin
        mem[wptr] <= din;
        wptr      <= wptr + AW'(1);
      end
      if (pop) rptr <= rptr + AW'(1);
      cnt <= cnt + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // An entry is live when its distance from the read pointer is below cnt.
  always_comb begin
    rd_mask = '0;
    off     = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off = AW'(i) - rptr;
      if ({1'b0, off} < cnt) rd_mask = rd_mask | reg_bit(mem[i].rd);
    end
  end

endmodule

// File: rtl/regfile_wb_arb.sv
// Two-requester (ALU, load) writeback arbiter in front of a single register
// file write port, with per-register pending-write scoreboard.
module regfile_wb_arb
  import regfile_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int RR_EN = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alu_valid,
  input  logic [REG_AW-1:0] alu_rd,
  input  logic [REG_DW-1:0] alu_data,
  output logic              alu_ready,
  input  logic              mem_valid,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic [REG_DW-1:0] mem_data,
  output logic              mem_ready,
  output logic [REG_AW-1:0] rd,
  output logic [REG_DW-1:0] datawr,
  output logic              regwr,
  output logic [31:0]       busy
);

  logic        alu_full, alu_empty, mem_full, mem_empty;
  logic        alu_push, mem_push, alu_pop, mem_pop;
  logic [31:0] alu_mask, mem_mask;
  wb_req_t     alu_head, mem_head, gnt_req;
  gnt_e        last_gnt, gnt_sel;
  logic        gnt_vld;

  assign alu_ready = ~alu_full;
  assign mem_ready = ~mem_full;
  assign alu_push  = alu_valid & alu_ready;
  assign mem_push  = mem_valid & mem_ready;

  wb_fifo #(.DEPTH(DEPTH)) u_alu_q (
    .clk     (clk),
    .rst     (rst),
    .push    (alu_push),
    .pop     (alu_pop),
    .din     ('{rd: alu_rd, data: alu_data}),
    .full    (alu_full),
    .empty   (alu_empty),
    .head    (alu_head),
    .rd_mask (alu_mask)
  );

  wb_fifo #(.DEPTH(DEPTH)) u_mem_q (
    .clk     (clk),
    .rst     (rst),
    .push    (mem_push),
    .pop     (mem_pop),
    .din     ('{rd: mem_rd, data: mem_data}),
    .full    (mem_full),
    .empty   (mem_empty),
    .head    (mem_head),
    .rd_mask (mem_mask)
  );

  // Tie-break: round-robin flips away from the last winner; fixed mode favours loads.
  always_comb begin
    gnt_vld = ~alu_empty | ~mem_empty;
    gnt_sel = GNT_ALU;
    if (~alu_empty && ~mem_empty)
      gnt_sel = (RR_EN != 0 && last_gnt == GNT_MEM) ? GNT_ALU : GNT_MEM;
    else if (~mem_empty)
      gnt_sel = GNT_MEM;
  end

  assign alu_pop = gnt_vld && (gnt_sel == GNT_ALU);
  assign mem_pop = gnt_vld && (gnt_sel == GNT_MEM);
  assign gnt_req = (gnt_sel == GNT_MEM) ? mem_head : alu_head;

  // XZR entries are consumed silently and leave rd/datawr untouched.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_gnt <= GNT_ALU;
      regwr    <= 1'b0;
      rd       <= '0;
      datawr   <= '0;
    end else begin
      regwr <= gnt_vld && (gnt_req.rd != XZR_IDX);
      if (gnt_vld) last_gnt <= gnt_sel;
      if (gnt_vld && gnt_req.rd != XZR_IDX) begin
        rd     <= gnt_req.rd;
        datawr <= gnt_req.data;
      end
    end
  end

  always_comb begin
    busy = alu_mask | mem_mask;
    if (regwr) busy = busy | reg_bit(rd);
  end

endmodule

// File: tb/tb_regfile_wb_arb.sv
// Directed bench: instance 0 round-robin, instance 1 fixed priority, both
// checked every cycle against a queue-level model plus literal expectations.
module tb_regfile_wb_arb;
  import regfile_pkg::*;

  localparam int DEPTH = 2;

  logic        clk, rst;
  logic        av [2], mv [2], ar [2], mr [2], o_wr [2];
  logic [4:0]  ard [2], mrd [2], o_rd [2];
  logic [63:0] ad [2], md [2], o_d [2];
  logic [31:0] o_busy [2];

  int checks = 0, errors = 0;

  regfile_wb_arb #(.DEPTH(DEPTH), .RR_EN(1)) u_rr (
    .clk(clk), .rst(rst),
    .alu_valid(av[0]), .alu_rd(ard[0]), .alu_data(ad[0]), .alu_ready(ar[0]),
    .mem_valid(mv[0]), .mem_rd(mrd[0]), .mem_data(md[0]), .mem_ready(mr[0]),
    .rd(o_rd[0]), .datawr(o_d[0]), .regwr(o_wr[0]), .busy(o_busy[0])
  );

  regfile_wb_arb #(.DEPTH(DEPTH), .RR_EN(0)) u_fp (
    .clk(clk), .rst(rst),
    .alu_valid(av[1]), .alu_rd(ard[1]), .alu_data(ad[1]), .alu_ready(ar[1]),
    .mem_valid(mv[1]), .mem_rd(mrd[1]), .mem_data(md[1]), .mem_ready(mr[1]),
    .rd(o_rd[1]), .datawr(o_d[1]), .regwr(o_wr[1]), .busy(o_busy[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // queue index q = 2*inst + side (side 0 = ALU, 1 = MEM), unbounded-ish ring
  wb_req_t     mq [4][256];
  int          mh [4], mt [4];
  int          last [2];
  logic        e_wr [2], known [2];
  logic [4:0]  e_rd [2];
  logic [63:0] e_d [2];
  bit          model_on = 0;

  function automatic int qsz(input int q);
    return mt[q] - mh[q];
  endfunction

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        mh[2*k] = 0; mt[2*k] = 0; mh[2*k+1] = 0; mt[2*k+1] = 0;
        last[k] = 0; e_wr[k] = 0; e_rd[k] = 0; e_d[k] = 0; known[k] = 1;
      end else begin
        bit acc_a, acc_m;
        int g;
        wb_req_t e;
        acc_a = av[k] && qsz(2*k) < DEPTH;
        acc_m = mv[k] && qsz(2*k+1) < DEPTH;
        g = -1;
        if (qsz(2*k) > 0 && qsz(2*k+1) > 0) g = (k == 0) ? 1 - last[k] : 1;
        else if (qsz(2*k) > 0) g = 0;
        else if (qsz(2*k+1) > 0) g = 1;
        e_wr[k] = 0;
        if (g >= 0) begin
          e = mq[2*k+g][mh[2*k+g] % 256];
          mh[2*k+g]++;
          last[k] = g;
          if (e.rd != 5'd31) begin
            e_wr[k] = 1; e_rd[k] = e.rd; e_d[k] = e.data; known[k] = 1;
          end else known[k] = 0;
        end
        if (acc_a) begin mq[2*k][mt[2*k] % 256] = '{rd: ard[k], data: ad[k]}; mt[2*k]++; end
        if (acc_m) begin mq[2*k+1][mt[2*k+1] % 256] = '{rd: mrd[k], data: md[k]}; mt[2*k+1]++; end
      end
    end
    model_on = 1;
  end

  function automatic logic [31:0] model_busy(input int k);
    logic [31:0] b = '0;
    for (int s = 0; s < 2; s++)
      for (int i = mh[2*k+s]; i < mt[2*k+s]; i++) b[mq[2*k+s][i % 256].rd] = 1'b1;
    if (e_wr[k]) b[e_rd[k]] = 1'b1;
    b[31] = 1'b0;
    return b;
  endfunction

  // ---------------- compare + shadow register files ----------------
  logic [63:0] xrf [2][32];
  int          wcnt [2];
  bit          log_en = 0;
  int          logn = 0;
  logic [4:0]  log_rd [16];
  int          log_cyc [16];
  int          cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (model_on) begin
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("model_regwr[%0d]", k), 64'(o_wr[k]), 64'(e_wr[k]));
        if (known[k]) begin
          chk($sformatf("model_rd[%0d]", k), 64'(o_rd[k]), 64'(e_rd[k]));
          chk($sformatf("model_datawr[%0d]", k), o_d[k], e_d[k]);
        end
        chk($sformatf("model_busy[%0d]", k), 64'(o_busy[k]), 64'(model_busy(k)));
        chk($sformatf("model_alu_ready[%0d]", k), 64'(ar[k]), 64'(qsz(2*k) < DEPTH));
        chk($sformatf("model_mem_ready[%0d]", k), 64'(mr[k]), 64'(qsz(2*k+1) < DEPTH));
        if (o_wr[k] === 1'b1) begin
          xrf[k][o_rd[k]] = o_d[k];
          wcnt[k]++;
          if (k == 0 && log_en && logn < 16) begin
            log_rd[logn] = o_rd[k]; log_cyc[logn] = cyc; logn++;
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  // Send na ALU and nm MEM requests on instance k with handshake; called at a negedge.
  task automatic send(input int k, input int na, input int nm,
                      input logic [4:0] rda, input logic [63:0] da,
                      input logic [4:0] rdm, input logic [63:0] dm);
    int sa = 0, sm = 0, guard = 0;
    bit a_ok, m_ok;
    while ((sa < na || sm < nm) && guard < 50) begin
      av[k] = (sa < na); ard[k] = rda; ad[k] = da + 64'(sa);
      mv[k] = (sm < nm); mrd[k] = rdm; md[k] = dm + 64'(sm);
      a_ok = av[k] && ar[k];
      m_ok = mv[k] && mr[k];
      @(negedge clk);
      sa += int'(a_ok); sm += int'(m_ok); guard++;
    end
    av[k] = 0; mv[k] = 0;
    if (guard >= 50) chk("send_timeout", 64'(guard), 64'(0));
  endtask

  initial begin
    int acc, w0;
    bit saw_low, any_wr;
    logic [31:0] bz;
    rst = 1;
    for (int k = 0; k < 2; k++) begin
      av[k] = 0; mv[k] = 0; ard[k] = 0; mrd[k] = 0; ad[k] = 0; md[k] = 0; wcnt[k] = 0;
      for (int r = 0; r < 32; r++) xrf[k][r] = '0;
    end
    repeat (2) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk("rst_regwr", 64'(o_wr[k]), 0);
      chk("rst_rd", 64'(o_rd[k]), 0);
      chk("rst_datawr", o_d[k], 0);
      chk("rst_busy", 64'(o_busy[k]), 0);
      chk("rst_alu_ready", 64'(ar[k]), 1);
      chk("rst_mem_ready", 64'(mr[k]), 1);
    end
    rst = 0;
    @(negedge clk);

    // ALU-only latency: accepted at edge N, written in the cycle after N+1
    av[0] = 1; ard[0] = 5'd3; ad[0] = 64'hAA;
    @(negedge clk);
    av[0] = 0;
    chk("lat_c1_busy3", 64'(o_busy[0][3]), 1);
    chk("lat_c1_regwr", 64'(o_wr[0]), 0);
    @(negedge clk);
    chk("lat_c2_regwr", 64'(o_wr[0]), 1);
    chk("lat_c2_rd", 64'(o_rd[0]), 3);
    chk("lat_c2_data", o_d[0], 64'hAA);
    chk("lat_c2_busy3", 64'(o_busy[0][3]), 1);
    @(negedge clk);
    chk("lat_c3_busy3", 64'(o_busy[0][3]), 0);
    chk("lat_c3_regwr", 64'(o_wr[0]), 0);

    // Round-robin tie: first tie goes to MEM, then strict alternation
    repeat (2) @(negedge clk);
    log_en = 1;
    send(0, 3, 3, 5'd1, 64'h1000, 5'd2, 64'h2000);
    repeat (8) @(negedge clk);
    log_en = 0;
    chk("rr_count", 64'(logn), 6);
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("rr_seq%0d", i), 64'(log_rd[i]), (i % 2 == 0) ? 64'd2 : 64'd1);
      if (i > 0) chk($sformatf("rr_gap%0d", i), 64'(log_cyc[i] - log_cyc[i-1]), 1);
    end

    // Back-pressure: both requesters stream, queues fill, nothing lost
    w0 = wcnt[0]; acc = 0; saw_low = 0;
    for (int i = 0; i < 8; i++) begin
      av[0] = 1; ard[0] = 5'(10 + i % 4); ad[0] = 64'h100 + 64'(i);
      mv[0] = 1; mrd[0] = 5'(20 + i % 4); md[0] = 64'h200 + 64'(i);
      acc += int'(ar[0]) + int'(mr[0]);
      if (!mr[0]) saw_low = 1;
      @(negedge clk);
    end
    av[0] = 0; mv[0] = 0;
    repeat (12) @(negedge clk);
    chk("bp_mem_ready_dropped", 64'(saw_low), 1);
    chk("bp_no_loss", 64'(wcnt[0] - w0), 64'(acc));

    // XZR entry is consumed without a write and never marks busy
    w0 = wcnt[0]; any_wr = 0; bz = '0;
    send(0, 1, 0, 5'd31, 64'h55, 5'd0, 64'h0);
    for (int i = 0; i < 5; i++) begin
      any_wr |= o_wr[0]; bz |= o_busy[0];
      @(negedge clk);
    end
    chk("xzr_no_regwr", 64'(any_wr), 0);
    chk("xzr_busy", 64'(bz), 0);
    chk("xzr_alu_ready", 64'(ar[0]), 1);

    // Same rd, fixed priority: sequential then simultaneous
    send(1, 0, 1, 5'd0, 64'h0, 5'd5, 64'd1);
    send(1, 1, 0, 5'd5, 64'd2, 5'd0, 64'h0);
    repeat (5) @(negedge clk);
    chk("same_rd_seq_x5", xrf[1][5], 64'd2);
    send(1, 1, 1, 5'd5, 64'd8, 5'd5, 64'd7);
    repeat (5) @(negedge clk);
    chk("same_rd_tie_x5", xrf[1][5], 64'd8);

    // Reset mid-operation with full queues; requests during reset dropped
    for (int i = 0; i < 4; i++) begin
      for (int k = 0; k < 2; k++) begin
        av[k] = 1; ard[k] = 5'(6 + i); ad[k] = 64'hA0 + 64'(i);
        mv[k] = 1; mrd[k] = 5'(12 + i); md[k] = 64'hB0 + 64'(i);
      end
      @(negedge clk);
    end
    rst = 1;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      av[k] = 0; mv[k] = 0;
      chk("midrst_regwr", 64'(o_wr[k]), 0);
      chk("midrst_busy", 64'(o_busy[k]), 0);
      chk("midrst_alu_ready", 64'(ar[k]), 1);
      chk("midrst_mem_ready", 64'(mr[k]), 1);
    end
    rst = 0;
    any_wr = 0;
    for (int i = 0; i < 6; i++) begin
      any_wr |= o_wr[0] | o_wr[1];
      @(negedge clk);
    end
    chk("midrst_no_stale", 64'(any_wr), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
